// File: rtl/stream_dmux_pkg.sv
// stream_dmux shared types and helpers.
// Optional broadcast mode: STREAM_DMUX_BROADCAST_EN.
package stream_dmux_pkg;

  localparam int MAX_CHANNELS = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_dmux_if.sv
// Input/output stream bundle for stream_dmux.
// in_bcast exists only with STREAM_DMUX_BROADCAST_EN.
interface stream_dmux_if
  import stream_dmux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8
);

  localparam int SEL_W = sel_width(CHANNELS);

  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic                      in_valid;
  logic                      in_ready;
  logic                      disable_i;
`ifdef STREAM_DMUX_BROADCAST_EN
  logic                      in_bcast;
`endif
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CNT_W-1:0]          drop_count;
  logic                      busy;

`ifdef STREAM_DMUX_BROADCAST_EN
  modport slave (
    input  in_data, in_sel, in_valid,
    input  disable_i, out_ready, in_bcast,
    output in_ready, out_data, out_valid,
    output drop_count, busy
  );

  modport master (
    output in_data, in_sel, in_valid,
    output disable_i, out_ready, in_bcast,
    input  in_ready, out_data, out_valid,
    input  drop_count, busy
  );
`else
  modport slave (
    input  in_data, in_sel, in_valid,
    input  disable_i, out_ready,
    output in_ready, out_data, out_valid,
    output drop_count, busy
  );

  modport master (
    output in_data, in_sel, in_valid,
    output disable_i, out_ready,
    input  in_ready, out_data, out_valid,
    input  drop_count, busy
  );
`endif

endinterface

// File: rtl/stream_dmux_slot.sv
// One-entry holding register for a single dmux channel.
// A load while draining refills in the same edge.
module stream_dmux_slot
  import stream_dmux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_load
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = load_data;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid    = (state_q == FULL);
  assign data     = data_q;
  assign can_load = (state_q == EMPTY) | out_ready;

endmodule

// File: rtl/stream_dmux.sv
// Registered 1-to-CHANNELS stream demultiplexer.
// Optional broadcast mode: STREAM_DMUX_BROADCAST_EN.
module stream_dmux
  import stream_dmux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8
) (
  input logic          clk,
  input logic          rst,
  stream_dmux_if.slave s
);

  localparam int SEL_W = sel_width(CHANNELS);
  localparam int NPAD  = 1 << SEL_W;

  logic [CHANNELS-1:0]            can_load;
  logic [CHANNELS-1:0]            load;
  logic [CHANNELS-1:0]            valid;
  logic [CHANNELS-1:0][WIDTH-1:0] data;
  logic [NPAD-1:0]                can_load_pad;
  logic                           in_range;
  logic                           bcast;
  logic                           in_ready;
  logic                           accept;
  logic [CNT_W-1:0]               drop_count_q;
  logic [CNT_W-1:0]               drop_count_d;

  // A full power-of-two select can never be out of range.
  if (NPAD == CHANNELS) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    localparam logic [SEL_W-1:0] LAST =
      SEL_W'(CHANNELS - 1);
    assign in_range = (s.in_sel <= LAST);
  end

`ifdef STREAM_DMUX_BROADCAST_EN
  assign bcast = s.in_bcast;
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    can_load_pad = '0;
    can_load_pad[CHANNELS-1:0] = can_load;
  end

  always_comb begin
    in_ready = 1'b0;
    if (!s.disable_i) begin
      if (bcast) begin
        in_ready = &can_load;
      end else if (in_range) begin
        in_ready = can_load_pad[s.in_sel];
      end else begin
        in_ready = 1'b1;
      end
    end
  end

  assign accept = s.in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      load[k] = accept &
        (bcast | (s.in_sel == SEL_W'(k)));
    end
  end

  // Out-of-range beats are consumed and counted.
  always_comb begin
    drop_count_d = drop_count_q;
    if (accept && !bcast && !in_range &&
        !(&drop_count_q)) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    stream_dmux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .load_data(s.in_data),
      .out_ready(s.out_ready[k]),
      .valid    (valid[k]),
      .data     (data[k]),
      .can_load (can_load[k])
    );
  end

  assign s.in_ready   = in_ready;
  assign s.out_valid  = valid;
  assign s.out_data   = data;
  assign s.busy       = |valid;
  assign s.drop_count = drop_count_q;

endmodule

// File: tb/tb_stream_dmux.sv
// Scoreboard bench for stream_dmux: 8-channel random/directed
// plus a 6-channel instance for out-of-range drops.
module tb_stream_dmux;
  import stream_dmux_pkg::*;

  localparam int W   = 8;
  localparam int CH  = 8;
  localparam int CH6 = 6;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_dmux_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(8)) i8 ();
  stream_dmux_if #(.WIDTH(W), .CHANNELS(CH6), .CNT_W(8)) i6 ();

  stream_dmux #(.WIDTH(W), .CHANNELS(CH), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .s(i8)
  );

  stream_dmux #(.WIDTH(W), .CHANNELS(CH6), .CNT_W(8)) dut6 (
    .clk(clk), .rst(rst), .s(i6)
  );

  beat_t exp_q[CH][$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < CH; k++) exp_q[k].delete();
  endtask

  // Monitor: a beat accepted in cycle N is visible from N+1.
  always @(negedge clk) begin : mon
    logic any;
    logic ev;
    if (!rst) begin
      any = 1'b0;
      for (int k = 0; k < CH; k++) begin
        ev = (exp_q[k].size() > 0) &&
             (exp_q[k][0].cyc < cyc);
        chk($sformatf("out_valid[%0d]", k),
            64'(i8.out_valid[k]), 64'(ev));
        if (ev) begin
          chk($sformatf("out_data[%0d]", k),
              64'(i8.out_data[k*W +: W]),
              64'(exp_q[k][0].data));
          if (i8.out_ready[k]) void'(exp_q[k].pop_front());
        end
        any |= ev;
      end
      chk("busy", 64'(i8.busy), 64'(any));
    end
  end

  // Drive one cycle, check in_ready against the model,
  // and push the expected beat(s) on acceptance.
  task automatic step(input logic       v,
                      input int         sel,
                      input logic [7:0] d,
                      input logic [7:0] ordy,
                      input logic       dis,
                      input logic       bc,
                      output logic      rdy);
    logic er;
    beat_t b;
    @(posedge clk);
    #1;
    i8.in_valid  = v;
    i8.in_sel    = sel[2:0];
    i8.in_data   = d;
    i8.out_ready = ordy;
    i8.disable_i = dis;
`ifdef STREAM_DMUX_BROADCAST_EN
    i8.in_bcast  = bc;
`endif
    #3;
    rdy = i8.in_ready;
    er  = !dis;
    if (bc) begin
      for (int k = 0; k < CH; k++)
        if (exp_q[k].size() != 0 && !ordy[k]) er = 1'b0;
    end else if (exp_q[sel].size() != 0 && !ordy[sel]) begin
      er = 1'b0;
    end
    chk("in_ready", 64'(rdy), 64'(er));
    chk("drop_count8", 64'(i8.drop_count), 64'd0);
    if (v && rdy) begin
      b.data = d;
      b.cyc  = cyc;
      if (bc) begin
        for (int k = 0; k < CH; k++) exp_q[k].push_back(b);
      end else begin
        exp_q[sel].push_back(b);
      end
    end
  endtask

  initial begin
    logic r;
    logic v, dis, bc;
    logic [7:0] ordy;
    int d6;

    rst = 1'b1;
    i8.in_valid = 0; i8.in_sel = '0; i8.in_data = '0;
    i8.disable_i = 0; i8.out_ready = '1;
    i6.in_valid = 0; i6.in_sel = '0; i6.in_data = '0;
    i6.disable_i = 0; i6.out_ready = '1;
`ifdef STREAM_DMUX_BROADCAST_EN
    i8.in_bcast = 0;
    i6.in_bcast = 0;
`endif
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk("rst_out_valid", 64'(i8.out_valid), 64'h00);
    chk("rst_drop", 64'(i8.drop_count), 64'd0);
    chk("rst_busy", 64'(i8.busy), 64'd0);
    chk("rst_in_ready", 64'(i8.in_ready), 64'd1);

    // Basic routing
    step(1, 5, 8'hA7, 8'hFF, 0, 0, r);
    chk("route_acc", 64'(r), 64'd1);
    step(0, 0, 8'h00, 8'hFF, 0, 0, r);
    chk("route_valid", 64'(i8.out_valid), 64'h20);
    chk("route_lane5", 64'(i8.out_data[47:40]), 64'hA7);
    step(0, 0, 8'h00, 8'hFF, 0, 0, r);
    chk("route_empty", 64'(i8.out_valid), 64'h00);

    // Backpressure on channel 3
    step(1, 3, 8'h11, 8'hF7, 0, 0, r);
    chk("bp_first", 64'(r), 64'd1);
    step(1, 3, 8'h22, 8'hF7, 0, 0, r);
    chk("bp_stall", 64'(r), 64'd0);
    chk("bp_hold", 64'(i8.out_data[31:24]), 64'h11);
    step(1, 1, 8'h33, 8'hF7, 0, 0, r);
    chk("bp_other", 64'(r), 64'd1);
    chk("bp_hold2", 64'(i8.out_data[31:24]), 64'h11);
    step(1, 3, 8'h22, 8'hFF, 0, 0, r);
    chk("bp_release", 64'(r), 64'd1);
    step(0, 0, 8'h00, 8'hFF, 0, 0, r);
    chk("bp_refill", 64'(i8.out_data[31:24]), 64'h22);
    chk("bp_refill_v", 64'(i8.out_valid[3]), 64'd1);
    step(0, 0, 8'h00, 8'hFF, 0, 0, r);

    // Disable while channels 0 and 2 drain
    step(1, 0, 8'h01, 8'hFA, 0, 0, r);
    step(1, 2, 8'h02, 8'hFA, 0, 0, r);
    step(1, 0, 8'h03, 8'hFF, 1, 0, r);
    chk("dis_ready", 64'(r), 64'd0);
    chk("dis_held", 64'(i8.out_valid & 8'h05), 64'h05);
    step(1, 2, 8'h04, 8'hFF, 1, 0, r);
    chk("dis_ready2", 64'(r), 64'd0);
    chk("dis_drained", 64'(i8.out_valid), 64'h00);

    // Mid-operation reset
    step(1, 4, 8'h44, 8'h00, 0, 0, r);
    @(posedge clk);
    #1 rst = 1'b1;
    i8.in_valid = 0;
    clear_model();
    #3 chk("pre_rst", 64'(i8.out_valid), 64'h10);
    @(posedge clk);
    #1 rst = 1'b0;
    #3 chk("rst_flush", 64'(i8.out_valid), 64'h00);

`ifdef STREAM_DMUX_BROADCAST_EN
    step(1, 6, 8'h66, 8'hBF, 0, 0, r);
    step(1, 0, 8'h5C, 8'hBF, 0, 1, r);
    chk("bc_block", 64'(r), 64'd0);
    step(1, 0, 8'h5C, 8'hFF, 0, 1, r);
    chk("bc_accept", 64'(r), 64'd1);
    step(0, 0, 8'h00, 8'hFF, 0, 0, r);
    chk("bc_valid", 64'(i8.out_valid), 64'hFF);
    chk("bc_lanes", i8.out_data, {8{8'h5C}});
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      dis  = ($urandom_range(0, 9) == 0);
      ordy = (i % 600 < 300) ? 8'($urandom | $urandom)
                             : 8'($urandom);
      bc   = 1'b0;
`ifdef STREAM_DMUX_BROADCAST_EN
      bc   = ($urandom_range(0, 15) == 0);
`endif
      step(v, $urandom_range(0, 7), 8'($urandom),
           ordy, dis, bc, r);
    end
    repeat (3) step(0, 0, 8'h00, 8'hFF, 0, 0, r);
    chk("final_empty", 64'(i8.out_valid), 64'h00);

    // Out-of-range drops on the 6-channel instance
    d6 = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      i6.in_valid = 1'b1;
      i6.in_sel   = 3'($urandom_range(6, 7));
      i6.in_data  = 8'($urandom);
      #3;
      chk("oor_ready", 64'(i6.in_ready), 64'd1);
      chk("oor_valid", 64'(i6.out_valid), 64'h00);
      chk("oor_count", 64'(i6.drop_count), 64'(d6));
      if (d6 < 255) d6++;
    end
    @(posedge clk);
    #1;
    i6.in_valid = 1'b1;
    i6.in_sel   = 3'd5;
    i6.in_data  = 8'h3C;
    #3 chk("oor_sat", 64'(i6.drop_count), 64'd255);
    @(posedge clk);
    #1 i6.in_valid = 1'b0;
    #3;
    chk("ch6_valid", 64'(i6.out_valid), 64'h20);
    chk("ch6_lane5", 64'(i6.out_data[47:40]), 64'h3C);
    chk("ch6_sat_hold", 64'(i6.drop_count), 64'd255);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_dmux.md
Name: stream_dmux

Overview:
- Parametrised, registered demultiplexer. Routes one input stream to one of CHANNELS output streams, chosen by a per-beat select.
- Has valid/ready handshakes on both sides. Each channel has its own one-entry holding register.
- Successor to the combinational 8-way decoder-demux used in the LEG datapath. Used between the instruction decode/write-back path and register, IO and RAM write ports.

Parameters:
- WIDTH, 8, data width of each beat.
- CHANNELS, 8, number of output channels; legal range 2..64.
- SEL_W, $clog2(CHANNELS), select width; derived, not overridden.
- CNT_W, 8, width of the dropped-beat counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  input beat payload.
- in_sel  in  SEL_W  destination channel index.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- disable_i  in  1  blocks acceptance; does not block draining.
- out_data  out  CHANNELS*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH].
- out_valid  out  CHANNELS  per-channel beat present.
- out_ready  in  CHANNELS  per-channel downstream ready.
- drop_count  out  CNT_W  saturating count of beats dropped for an out-of-range select.
- busy  out  1  OR of out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, drop_count=0. in_ready may be high in the first cycle after reset. Reset mid-transfer discards all held beats with no flush.
- Slot state: each channel slot is a 2-state machine, EMPTY and FULL.
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on out_ready[k] with no load in the same cycle.
  - FULL -> FULL on out_ready[k] with a load in the same cycle (pass-through refill; this gives full throughput).
- Acceptance: accept = in_valid & in_ready.
  - in_sel < CHANNELS: in_ready = !disable_i & (!out_valid[in_sel] | out_ready[in_sel]).
  - in_sel >= CHANNELS (only possible when CHANNELS is not a power of 2): in_ready = !disable_i. The beat is consumed and dropped, and drop_count increments, saturating at all-ones.
- in_ready is combinational from in_sel, disable_i, out_valid and out_ready. It is never a function of in_valid.
- Latency: a beat accepted in cycle N appears on out_valid/out_data in cycle N+1.
- Data stability: out_data[k] holds while out_valid[k] is high and out_ready[k] is low. It is updated only on a load.
- Independence: other channels drain independently. A stalled channel blocks only beats addressed to it (head-of-line at input).
- Ordering: per-channel order is preserved. There is no cross-channel ordering guarantee.
- Disable: disable_i=1 forces in_ready=0. Held beats still drain.
- Simultaneous drain and load on one channel: the new data replaces the old in the same edge. No bubble, no loss.

Optional Feature:
- Macro: STREAM_DMUX_BROADCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast=1, in_sel is ignored. in_ready = !disable_i & every slot is (EMPTY or out_ready).
  - On accept, all CHANNELS slots load in_data. drop_count is unaffected.
- Undefined:
  - Port absent. Behaviour exactly as above.

Decomposition:
- Package stream_dmux_pkg holds:
  - function sel_width(n) = $clog2(n), with a minimum of 1;
  - typedef slot_state_e {EMPTY, FULL};
  - localparam MAX_CHANNELS=64.
- Sub-module stream_dmux_slot: one WIDTH-bit holding register with valid/ready.
  - Inputs: load, load_data, out_ready.
  - Outputs: valid, data, can_load.
  - Instantiated CHANNELS times in a generate loop.
- Top level holds: select decode, in_ready mux, drop counter, broadcast logic.

Test Plan:
- Reset/idle: rst high 2 cycles, then low, with CHANNELS=8 and all out_ready=1. Required: out_valid=0x00, drop_count=0, busy=0, in_ready=1.
- Basic routing: send in_sel=5, in_data=0xA7, out_ready all 1. Required: next cycle out_valid=0x20 and out_data[47:40]=0xA7. The cycle after: out_valid=0x00.
- Backpressure: out_ready[3]=0, two beats to sel 3 (0x11 then 0x22). Required: first accepted; second sees in_ready=0 and stalls. out_data[31:24] holds 0x11. Beats to sel 1 are still accepted. Releasing out_ready[3] accepts 0x22 in the same cycle 0x11 drains.
- Out-of-range select: CHANNELS=6, 300 beats with in_sel=7. Required: in_ready=1 throughout, out_valid stays 0, drop_count saturates at 255.
- Disable and mid-op reset: fill channels 0 and 2, set disable_i=1. Required: in_ready=0 while both channels drain normally. Then fill channel 4 and assert rst. Required: out_valid=0 the next cycle.
- Broadcast (macro on): in_bcast=1, in_data=0x5C, out_ready[6]=0 with slot 6 FULL. Required: in_ready=0. After slot 6 drains, accept; out_valid=0xFF, every lane =0x5C.
